// File: rtl/generic_bus_mem_responder_if.sv
// generic_bus_mem_responder_if: generic bus request/response bundle; err present with GENBUS_RESP_ERR_EN
interface generic_bus_mem_responder_if;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;
`ifdef GENBUS_RESP_ERR_EN
  logic        err;
  modport master (output ren, wen, addr, wdata, byte_en, input rdata, busy, err);
  modport slave  (input ren, wen, addr, wdata, byte_en, output rdata, busy, err);
`else
  modport master (output ren, wen, addr, wdata, byte_en, input rdata, busy);
  modport slave  (input ren, wen, addr, wdata, byte_en, output rdata, busy);
`endif
endinterface

// File: rtl/generic_bus_mem_responder.sv
// generic_bus_mem_responder: SRAM-backed generic bus responder with LATENCY wait cycles; GENBUS_RESP_ERR_EN adds the err port
module generic_bus_mem_responder #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input logic CLK,
  input logic nRST,
  generic_bus_mem_responder_if.slave bus
);
  localparam int CW = LATENCY < 1 ? 1 : $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] addr_q, wdata_q, rdata_q, c_addr, c_wdata, off;
  logic [3:0] be_q, c_be;
  logic wr_q, c_wr, commit, in_rng, req;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0] mem [2**ADDR_BITS];
`ifdef GENBUS_RESP_ERR_EN
  logic err_q;
  assign bus.err = err_q;
`endif
  assign req = bus.ren | bus.wen;
  assign bus.busy = state != DONE;
  assign bus.rdata = rdata_q;
  // A zero-latency commit happens straight from IDLE, so it must use the live request instead of the latch
  always_comb begin
    c_addr = state == IDLE ? bus.addr : addr_q;
    c_wdata = state == IDLE ? bus.wdata : wdata_q;
    c_be = state == IDLE ? bus.byte_en : be_q;
    c_wr = state == IDLE ? bus.wen : wr_q;
    off = c_addr - BASE_ADDR;
    in_rng = c_addr >= BASE_ADDR && (33'(off) >> (ADDR_BITS + 2)) == 33'd0;
    idx = off[ADDR_BITS+1:2];
  end
  // Next state: accept in IDLE, count down in WAIT (dropped request aborts), DONE lasts one cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    commit = 1'b0;
    if (state == IDLE) begin
      if (req) begin
        cnt_n = CW'(LATENCY);
        commit = LATENCY == 0;
        state_n = LATENCY == 0 ? DONE : WAIT;
      end
    end else if (state == WAIT) begin
      cnt_n = cnt - CW'(1);
      commit = req && cnt == CW'(1);
      state_n = !req ? IDLE : commit ? DONE : WAIT;
    end else begin
      state_n = IDLE;
    end
  end
  // FSM state, request latch and read/err result registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      wr_q <= 1'b0;
      rdata_q <= '0;
`ifdef GENBUS_RESP_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && req) begin
        addr_q <= bus.addr;
        wdata_q <= bus.wdata;
        be_q <= bus.byte_en;
        wr_q <= bus.wen;
      end
      if (commit && !c_wr) rdata_q <= in_rng ? mem[idx] : 32'hBAD1_BAD1;
`ifdef GENBUS_RESP_ERR_EN
      err_q <= commit && !in_rng;
`endif
    end
  end
  // Byte-lane write at the commit edge; out-of-range writes are dropped
  always_ff @(posedge CLK) begin
    if (commit && c_wr && in_rng)
      for (int i = 0; i < 4; i++)
        if (c_be[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_generic_bus_mem_responder.sv
// tb_generic_bus_mem_responder: scoreboard bench over three responders (LATENCY 2, 0 with BASE 0x100, 3)
module tb_generic_bus_mem_responder;
  typedef struct {
    int d;
    int cyc;
    bit rd;
    logic [31:0] v;
    bit e;
  } exp_t;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  logic ren [3];
  logic wen [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0] be [3];
  logic busy [3];
  logic [31:0] rdata [3];
  generic_bus_mem_responder_if b0();
  generic_bus_mem_responder_if b1();
  generic_bus_mem_responder_if b2();
  generic_bus_mem_responder #(.LATENCY(2)) u0 (.CLK(CLK), .nRST(nRST), .bus(b0));
  generic_bus_mem_responder #(.LATENCY(0), .BASE_ADDR(32'h100)) u1 (.CLK(CLK), .nRST(nRST), .bus(b1));
  generic_bus_mem_responder #(.LATENCY(3)) u2 (.CLK(CLK), .nRST(nRST), .bus(b2));
  assign b0.ren = ren[0];
  assign b0.wen = wen[0];
  assign b0.addr = addr[0];
  assign b0.wdata = wdata[0];
  assign b0.byte_en = be[0];
  assign b1.ren = ren[1];
  assign b1.wen = wen[1];
  assign b1.addr = addr[1];
  assign b1.wdata = wdata[1];
  assign b1.byte_en = be[1];
  assign b2.ren = ren[2];
  assign b2.wen = wen[2];
  assign b2.addr = addr[2];
  assign b2.wdata = wdata[2];
  assign b2.byte_en = be[2];
  assign busy[0] = b0.busy;
  assign busy[1] = b1.busy;
  assign busy[2] = b2.busy;
  assign rdata[0] = b0.rdata;
  assign rdata[1] = b1.rdata;
  assign rdata[2] = b2.rdata;
`ifdef GENBUS_RESP_ERR_EN
  logic err [3];
  assign err[0] = b0.err;
  assign err[1] = b1.err;
  assign err[2] = b2.err;
`endif
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string n, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", n, d, cyc, act, exp);
    end
  endtask
  int k;
  exp_t em;
  // Monitor: every completion pops the oldest expectation for that responder
  always @(negedge CLK) begin
    for (int d = 0; d < 3; d++) begin
      if (nRST && !busy[d]) begin
        k = -1;
        for (int i = 0; i < q.size(); i++) if (k < 0 && q[i].d == d) k = i;
        if (k < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done dut%0d cycle %0d: got busy=0 expected busy=1", d, cyc);
        end else begin
          em = q[k];
          q.delete(k);
          chk("done_cycle", d, 32'(cyc), 32'(em.cyc));
          if (em.rd) chk("rdata", d, rdata[d], em.v);
`ifdef GENBUS_RESP_ERR_EN
          chk("err", d, 32'(err[d]), 32'(em.e));
`endif
        end
      end
    end
  end
  function automatic int lat(input int d);
    return d == 0 ? 2 : d == 1 ? 0 : 3;
  endfunction
  task automatic push(input int d, input int c, input bit rd, input logic [31:0] v, input bit e);
    exp_t x;
    x.d = d;
    x.cyc = c;
    x.rd = rd;
    x.v = v;
    x.e = e;
    q.push_back(x);
  endtask
  task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, input logic [31:0] v, input bit e);
    int t;
    @(posedge CLK);
    #1;
    push(d, cyc + 1 + lat(d), !w, v, e);
    ren[d] = !w;
    wen[d] = w;
    addr[d] = a;
    wdata[d] = wd;
    be[d] = b;
    for (t = 0; t < 20; t++) begin
      @(negedge CLK);
      if (!busy[d]) break;
    end
    if (t == 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut%0d: got busy=1 for 20 cycles expected busy=0", d);
    end
    @(posedge CLK);
    #1;
    ren[d] = 1'b0;
    wen[d] = 1'b0;
  endtask
  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      ren[d] = 1'b0;
      wen[d] = 1'b0;
      addr[d] = '0;
      wdata[d] = '0;
      be[d] = '0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("reset_busy", d, 32'(busy[d]), 32'd1);
      chk("reset_rdata", d, rdata[d], 32'h0);
    end
    #10 nRST = 1'b1;
    xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    xact(0, 0, 32'h10, 0, 0, 32'hDEADBEEF, 0);
    xact(0, 1, 32'h10, 32'h00AA0000, 4'b0100, 0, 0);
    xact(0, 0, 32'h10, 0, 0, 32'hDEAABEEF, 0);
    xact(0, 1, 32'h10, 32'h11223344, 4'b1001, 0, 0);
    xact(0, 0, 32'h13, 0, 0, 32'h11AABE44, 0);
    xact(0, 1, 32'h0, 32'h0BADF00D, 4'hF, 0, 0);
    xact(0, 1, 32'hFFC, 32'hCAFE0001, 4'hF, 0, 0);
    xact(0, 0, 32'hFFC, 0, 0, 32'hCAFE0001, 0);
    xact(0, 1, 32'h1000, 32'h55555555, 4'hF, 0, 1);
    xact(0, 0, 32'h0, 0, 0, 32'h0BADF00D, 0);
    xact(0, 0, 32'h1000, 0, 0, 32'hBAD1BAD1, 1);
    xact(0, 0, 32'hFFFFFFFC, 0, 0, 32'hBAD1BAD1, 1);
    xact(1, 1, 32'h110, 32'hCAFEF00D, 4'hF, 0, 0);
    xact(1, 0, 32'hFC, 0, 0, 32'hBAD1BAD1, 1);
    xact(1, 0, 32'h1100, 0, 0, 32'hBAD1BAD1, 1);
    @(posedge CLK);
    #1;
    n = cyc;
    for (int i = 0; i < 4; i++) push(1, n + 1 + 2 * i, 1, 32'hCAFEF00D, 0);
    ren[1] = 1'b1;
    addr[1] = 32'h110;
    repeat (8) @(posedge CLK);
    #1;
    ren[1] = 1'b0;
    xact(2, 1, 32'h20, 32'h11112222, 4'hF, 0, 0);
    @(posedge CLK);
    #1;
    wen[2] = 1'b1;
    addr[2] = 32'h20;
    wdata[2] = 32'h12345678;
    be[2] = 4'hF;
    @(posedge CLK);
    #1;
    wen[2] = 1'b0;
    addr[2] = 32'h0;
    @(negedge CLK);
    chk("abort_busy", 2, 32'(busy[2]), 32'd1);
    xact(2, 0, 32'h20, 0, 0, 32'h11112222, 0);
    xact(0, 1, 32'h30, 32'hA5A5A5A5, 4'hF, 0, 0);
    xact(0, 0, 32'h30, 0, 0, 32'hA5A5A5A5, 0);
    @(posedge CLK);
    #1;
    wen[0] = 1'b1;
    addr[0] = 32'h30;
    wdata[0] = 32'h0;
    be[0] = 4'hF;
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    wen[0] = 1'b0;
    #1;
    chk("rst_busy", 0, 32'(busy[0]), 32'd1);
    chk("rst_rdata", 0, rdata[0], 32'h0);
`ifdef GENBUS_RESP_ERR_EN
    chk("rst_err", 0, 32'(err[0]), 32'd0);
`endif
    @(negedge CLK);
    nRST = 1'b1;
    xact(0, 0, 32'h30, 0, 0, 32'hA5A5A5A5, 0);
    repeat (5) @(posedge CLK);
    chk("queue_empty", 0, 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
